// File: rtl/conv_accel_pkg.sv
// Shared types and helpers for the 1-D convolution accelerator.
package conv_accel_pkg;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_COMPUTE = 1'b1
  } state_t;

  localparam int CA_DW    = 32;
  localparam int CA_ACC_W = 64;

  // Index width for an n-entry array; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic signed [CA_ACC_W-1:0] sext_prod(
    input logic signed [CA_DW-1:0] a,
    input logic signed [CA_DW-1:0] b
  );
    logic signed [2*CA_DW-1:0] p;
    p = a * b;
    return CA_ACC_W'(p);
  endfunction

endpackage

// File: rtl/conv_accel_if.sv
// Host-side bus of the convolution accelerator: word writes, result pops, status.
interface conv_accel_if #(
  parameter int DW    = 32,
  parameter int ACC_W = 64
);
  logic [31:0]      addr;
  logic             en_w;
  logic [DW-1:0]    data_in;
  logic             en_r;
  logic [ACC_W-1:0] data_out;
  logic             out_empty;
  logic             out_full;
  logic             busy;
  logic             done;
  logic             wr_err;

  modport master (
    output addr, en_w, data_in, en_r,
    input  data_out, out_empty, out_full, busy, done, wr_err
  );

  modport slave (
    input  addr, en_w, data_in, en_r,
    output data_out, out_empty, out_full, busy, done, wr_err
  );
endinterface

// File: rtl/accel_out_fifo.sv
// Synchronous first-word-fall-through result FIFO; head reads 0 while empty.
module accel_out_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp;
  logic         pop_ok, push_ok;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop_ok  = pop && !empty;
  // A full FIFO still takes a push when a pop frees the head slot in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign head    = empty ? '0 : mem[rp[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/conv_accel_engine.sv
// Memory-mapped 1-D convolution engine: slot load, tap-serial MAC, FIFO output.
// Define CONV_ACCEL_RELU_EN to clamp negative results to zero before they are queued.
module conv_accel_engine
  import conv_accel_pkg::*;
#(
  parameter int DW          = 32,
  parameter int ACC_W       = 64,
  parameter int N_DATA      = 4,
  parameter int N_TAPS      = 3,
  parameter int FILT_BASE   = 60,
  parameter int OFIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  conv_accel_if.slave bus
);
  localparam int N_OUT = N_DATA - N_TAPS + 1;
  localparam int DIW   = idx_w(N_DATA);
  localparam int FIW   = idx_w(N_TAPS);
  localparam int JW    = idx_w(N_OUT);

  state_t state;

  logic [DW-1:0]           data_q [N_DATA];
  logic [DW-1:0]           filt_q [N_TAPS];
  logic [N_DATA-1:0]       dvalid, dset;
  logic [N_TAPS-1:0]       fvalid, fset;
  logic [JW-1:0]           j;
  logic [FIW-1:0]          k;
  logic signed [ACC_W-1:0] acc, prod, acc_nx, push_data;
  logic [31:0]             word;
  logic                    is_data, is_filt, all_set;
  logic [DIW-1:0]          d_idx, di;
  logic [FIW-1:0]          f_idx;
  logic [DW-1:0]           d_sel, f_sel;
  logic                    last_tap, last_out, push_req, stall;
  logic                    fifo_full, fifo_empty;
  logic                    done_q, wr_err_q;

  assign word    = {2'b00, bus.addr[31:2]};
  assign is_data = word < 32'(N_DATA);
  assign is_filt = (word >= 32'(FILT_BASE)) && (word < 32'(FILT_BASE + N_TAPS));
  assign d_idx   = word[DIW-1:0];
  assign f_idx   = FIW'(word - 32'(FILT_BASE));

  always_comb begin
    dset = '0;
    fset = '0;
    if (bus.en_w && state == S_IDLE) begin
      if (is_data) dset[d_idx] = 1'b1;
      if (is_filt) fset[f_idx] = 1'b1;
    end
  end

  // The write that fills the last slot counts toward starting the run.
  assign all_set = (&(dvalid | dset)) && (&(fvalid | fset));

  assign di    = DIW'(j) + DIW'(k);
  assign d_sel = data_q[di];
  assign f_sel = filt_q[k];

  generate
    if (DW == CA_DW && ACC_W == CA_ACC_W) begin : g_pkg_mul
      assign prod = sext_prod(d_sel, f_sel);
    end else begin : g_gen_mul
      assign prod = ACC_W'(signed'(d_sel)) * ACC_W'(signed'(f_sel));
    end
  endgenerate

  assign acc_nx = ((k == '0) ? '0 : acc) + prod;

`ifdef CONV_ACCEL_RELU_EN
  assign push_data = acc_nx[ACC_W-1] ? '0 : acc_nx;
`else
  assign push_data = acc_nx;
`endif

  assign last_tap = (k == FIW'(N_TAPS - 1));
  assign last_out = (j == JW'(N_OUT - 1));
  assign push_req = (state == S_COMPUTE) && last_tap;
  // Hold the MAC while the result has nowhere to go; a same-cycle pop makes room.
  assign stall    = push_req && fifo_full && !bus.en_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      dvalid   <= '0;
      fvalid   <= '0;
      j        <= '0;
      k        <= '0;
      acc      <= '0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          dvalid <= dvalid | dset;
          fvalid <= fvalid | fset;
          if (all_set) begin
            state <= S_COMPUTE;
            j     <= '0;
            k     <= '0;
          end
        end
        default: begin
          if (bus.en_w && (is_data || is_filt)) wr_err_q <= 1'b1;
          if (!stall) begin
            acc <= acc_nx;
            if (last_tap) begin
              k <= '0;
              if (last_out) begin
                state  <= S_IDLE;
                done_q <= 1'b1;
                dvalid <= '0;
                fvalid <= '0;
                j      <= '0;
              end else begin
                j <= j + 1'b1;
              end
            end else begin
              k <= k + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && bus.en_w) begin
      if (is_data) data_q[d_idx] <= bus.data_in;
      if (is_filt) filt_q[f_idx] <= bus.data_in;
    end
  end

  accel_out_fifo #(
    .W     (ACC_W),
    .DEPTH (OFIFO_DEPTH)
  ) u_ofifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data (push_data),
    .pop       (bus.en_r),
    .head      (bus.data_out),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign bus.out_empty = fifo_empty;
  assign bus.out_full  = fifo_full;
  assign bus.busy      = (state == S_COMPUTE);
  assign bus.done      = done_q;
  assign bus.wr_err    = wr_err_q;
endmodule

// File: tb/tb_conv_accel_engine.sv
// Scoreboard bench: loads push expected results, a monitor drains and compares.
module tb_conv_accel_engine;
  localparam int N_DATA = 4;
  localparam int N_TAPS = 3;
  localparam int N_OUT  = N_DATA - N_TAPS + 1;
  localparam int FBASE  = 60;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  conv_accel_if #(.DW(32), .ACC_W(64)) bus ();

  conv_accel_engine u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int     n_vec  = 0;
  int     n_miss = 0;
  bit     drain_en = 1'b0;
  longint exp_q[$];
  int     m_d[N_DATA];
  int     m_f[N_TAPS];

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic longint post(input longint v);
`ifdef CONV_ACCEL_RELU_EN
    return (v < 0) ? 64'sd0 : v;
`else
    return v;
`endif
  endfunction

  // Reference dot products from the slot values the bench believes are stored.
  task automatic push_exp();
    for (int jj = 0; jj < N_OUT; jj++) begin
      longint s = 0;
      for (int kk = 0; kk < N_TAPS; kk++) s += longint'(m_d[jj+kk]) * longint'(m_f[kk]);
      exp_q.push_back(post(s));
    end
  endtask

  task automatic wr(input int word, input int val);
    @(negedge clk);
    bus.addr    = 32'(word) << 2;
    bus.data_in = 32'(val);
    bus.en_w    = 1'b1;
    @(negedge clk);
    bus.en_w    = 1'b0;
  endtask

  task automatic load(input int d[N_DATA], input int f[N_TAPS]);
    for (int i = 0; i < N_DATA; i++) begin wr(i, d[i]); m_d[i] = d[i]; end
    for (int i = 0; i < N_TAPS; i++) begin wr(FBASE + i, f[i]); m_f[i] = f[i]; end
    push_exp();
  endtask

  task automatic wait_done(input string name);
    int c;
    for (c = 0; c < 200 && !bus.done; c++) @(negedge clk);
    chk(name, longint'(bus.done), 1);
    @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 200 && !(exp_q.size() == 0 && bus.out_empty); c++) @(negedge clk);
    chk(name, longint'(exp_q.size()), 0);
  endtask

  // Monitor: pops the FIFO head whenever draining is enabled and compares it.
  initial begin
    bus.en_r = 1'b0;
    forever begin
      @(negedge clk);
      if (drain_en && !reset && !bus.out_empty) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL result: got %0d, none expected", longint'($signed(bus.data_out)));
        end else begin
          chk("result", longint'($signed(bus.data_out)), exp_q.pop_front());
        end
        bus.en_r = 1'b1;
      end else begin
        bus.en_r = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_n, done_n, done_at;
    bus.addr = '0; bus.en_w = 1'b0; bus.data_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_empty", longint'(bus.out_empty), 1);
    chk("rst_dout",  longint'(bus.data_out), 0);
    chk("rst_busy",  longint'(bus.busy), 0);
    chk("rst_full",  longint'(bus.out_full), 0);
    chk("rst_done",  longint'(bus.done), 0);
    chk("rst_werr",  longint'(bus.wr_err), 0);
    reset = 1'b0;
    drain_en = 1'b1;

    // 1: basic run, done latency and busy length
    load('{1, 2, 3, 4}, '{1, 1, 1});
    busy_n = 0; done_n = 0; done_at = -1;
    for (int c = 1; c <= 20; c++) begin
      if (bus.busy) busy_n++;
      if (bus.done) begin done_n++; if (done_at < 0) done_at = c; end
      @(negedge clk);
    end
    chk("busy_cycles", busy_n, 6);
    chk("done_at", done_at, 7);
    chk("done_width", done_n, 1);
    wait_drain("drain_t1");

    // 2: signed data, raw or clamped
    load('{-2, 3, -4, 5}, '{1, 2, 1});
    wait_done("done_t2a"); wait_drain("drain_t2a");
    load('{1, -5, -5, 1}, '{1, 1, 1});
    wait_done("done_t2b"); wait_drain("drain_t2b");

    // 3: FIFO fills, engine stalls, popping releases it with nothing lost
    drain_en = 1'b0;
    load('{1, 2, 3, 4}, '{1, 1, 1}); wait_done("done_t3a");
    load('{1, 2, 3, 4}, '{1, 1, 1}); wait_done("done_t3b");
    chk("full_after_4", longint'(bus.out_full), 1);
    load('{1, 2, 3, 4}, '{1, 1, 1});
    repeat (12) @(negedge clk);
    chk("stall_busy", longint'(bus.busy), 1);
    chk("stall_full", longint'(bus.out_full), 1);
    drain_en = 1'b1;
    wait_done("done_t3c"); wait_drain("drain_t3");

    // 4: partial load does not start; rewrites keep the last value; unmapped word ignored
    wr(0, 1); m_d[0] = 1;
    wr(1, 2); m_d[1] = 2;
    for (int i = 0; i < N_TAPS; i++) begin wr(FBASE + i, 1); m_f[i] = 1; end
    wr(3, 7);
    wr(3, 4); m_d[3] = 4;
    wr(10, 99);
    repeat (10) @(negedge clk);
    chk("partial_idle", longint'(bus.busy), 0);
    wr(2, 5); m_d[2] = 5;
    push_exp();
    wait_done("done_t4"); wait_drain("drain_t4");

    // 5: write during COMPUTE is dropped and flagged
    load('{1, 2, 3, 4}, '{2, 0, -1});
    wr(0, 100);
    chk("wr_err_set", longint'(bus.wr_err), 1);
    wait_done("done_t5"); wait_drain("drain_t5");
    chk("wr_err_sticky", longint'(bus.wr_err), 1);

    // 6: reset in the middle of COMPUTE aborts everything
    drain_en = 1'b0;
    load('{1, 2, 3, 4}, '{1, 1, 1});
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    exp_q.delete();
    chk("abort_empty", longint'(bus.out_empty), 1);
    chk("abort_dout",  longint'(bus.data_out), 0);
    chk("abort_busy",  longint'(bus.busy), 0);
    chk("abort_werr",  longint'(bus.wr_err), 0);
    chk("abort_full",  longint'(bus.out_full), 0);
    @(negedge clk);
    reset = 1'b0;
    drain_en = 1'b1;
    load('{2, 0, 1, 3}, '{1, -1, 2});
    wait_done("done_t6"); wait_drain("drain_t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
